// File: rtl/fetch_pc_unit.sv
// Program-counter / fetch-address stage: steps the PC by 4, redirects on branches and
// jumps, and issues fetch requests to instruction memory over a valid/ready handshake.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_off_x4,
    input  logic [31:0] redir_base_pc,
    input  logic        jump,
    input  logic [25:0] jump_idx,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        flush,
    output logic        align_err
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic        pend_valid_q, pend_valid_d;
    logic        flush_q, flush_d;

    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic [31:0] raw_tgt;
    logic [31:0] redir_tgt;
    logic        redir;
    logic        accept;
    logic [31:0] pc_inc;

    // Redirect target selection; jump wins over a simultaneous taken branch.
    always_comb begin
        br_tgt    = redir_base_pc + branch_off_x4;
        j_tgt     = {redir_base_pc[31:28], jump_idx, 2'b00};
        raw_tgt   = jump ? j_tgt : br_tgt;
        redir_tgt = {raw_tgt[31:2], 2'b00};
        redir     = (state_q != BOOT) && (jump || branch_taken);
    end

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = ~stall;
                if (stall) begin
                    state_d = STALL;
                end
            end
            STALL: begin
                if (!stall) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign accept = imem_req & imem_ready;
    assign pc_inc = pc_q + 32'd4;

    // A fresh redirect beats a parked one, which beats sequential stepping; a redirect
    // that cannot be taken this cycle parks in the single pending slot.
    always_comb begin
        pc_d         = pc_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        flush_d      = redir;
        if (accept) begin
            pend_valid_d = 1'b0;
            if (redir) begin
                pc_d = redir_tgt;
            end else if (pend_valid_q) begin
                pc_d = pend_q;
            end else begin
                pc_d = pc_inc;
            end
        end else if (redir) begin
            pend_valid_d = 1'b1;
            pend_d       = redir_tgt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            pend_q       <= 32'h0000_0000;
            pend_valid_q <= 1'b0;
            flush_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            flush_q      <= flush_d;
        end
    end

    assign pc        = pc_q;
    assign pc_plus4  = pc_inc;
    assign flush     = flush_q;
    assign align_err = redir && (raw_tgt[1:0] != 2'b00);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: stimulus pushes predicted per-cycle outputs and
// predicted fetch addresses; a monitor pops and compares them independently.
module tb_fetch_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_off_x4;
    logic [31:0] redir_base_pc;
    logic        jump;
    logic [25:0] jump_idx;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        flush;
    logic        align_err;

    always #5 clk = ~clk;

    fetch_pc_unit #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_off_x4 (branch_off_x4),
        .redir_base_pc (redir_base_pc),
        .jump          (jump),
        .jump_idx      (jump_idx),
        .imem_ready    (imem_ready),
        .imem_req      (imem_req),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .flush         (flush),
        .align_err     (align_err)
    );

    typedef struct {
        logic        req;
        logic [31:0] pc;
        logic        flush;
        logic        align;
    } cyc_t;

    cyc_t        cyc_q[$];
    logic [31:0] fetch_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: what the fetch stage has promised so far.
    logic        m_booted;
    logic        m_held;
    logic [31:0] m_pc;
    logic        m_pend_v;
    logic [31:0] m_pend;
    logic        m_flush;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_booted = 1'b0;
        m_held   = 1'b0;
        m_pc     = RESET_PC;
        m_pend_v = 1'b0;
        m_pend   = 32'h0;
        m_flush  = 1'b0;
    endtask

    // Drive one cycle of inputs, predict what the DUT shows during it, then advance the model.
    task automatic applyStimulus(input logic i_rst_n, input logic i_stall, input logic i_br,
                                 input logic [31:0] i_off, input logic [31:0] i_base,
                                 input logic i_jmp, input logic [25:0] i_idx,
                                 input logic i_ready);
        cyc_t        rec;
        logic        req;
        logic        redir;
        logic [31:0] raw;
        logic [31:0] tgt;
        rst_n         = i_rst_n;
        stall         = i_stall;
        branch_taken  = i_br;
        branch_off_x4 = i_off;
        redir_base_pc = i_base;
        jump          = i_jmp;
        jump_idx      = i_idx;
        imem_ready    = i_ready;
        if (!i_rst_n) begin
            modelReset();
            rec = '{req: 1'b0, pc: RESET_PC, flush: 1'b0, align: 1'b0};
            cyc_q.push_back(rec);
        end else begin
            req   = m_booted && !m_held && !i_stall;
            redir = m_booted && (i_jmp || i_br);
            raw   = i_jmp ? {i_base[31:28], i_idx, 2'b00} : i_base + i_off;
            tgt   = raw & 32'hFFFF_FFFC;
            rec   = '{req: req, pc: m_pc, flush: m_flush, align: redir && (raw % 4 != 0)};
            cyc_q.push_back(rec);
            if (req && i_ready) begin
                fetch_q.push_back(m_pc);
                if (redir) m_pc = tgt;
                else if (m_pend_v) m_pc = m_pend;
                else m_pc = m_pc + 32'd4;
                m_pend_v = 1'b0;
            end else if (redir) begin
                m_pend_v = 1'b1;
                m_pend   = tgt;
            end
            m_flush  = redir;
            m_held   = m_booted && i_stall;
            m_booted = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic i_ready);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 26'h0, i_ready);
    endtask

    task automatic branch(input logic [31:0] base, input logic [31:0] off, input logic i_ready);
        applyStimulus(1'b1, 1'b0, 1'b1, off, base, 1'b0, 26'h0, i_ready);
    endtask

    // Monitor: per-cycle outputs every cycle, fetch addresses on each accepted request.
    initial begin
        cyc_t rec;
        forever begin
            @(negedge clk);
            if (cyc_q.size() > 0) begin
                rec = cyc_q.pop_front();
                checkOutput("imem_req", {31'h0, imem_req}, {31'h0, rec.req});
                checkOutput("pc", pc, rec.pc);
                checkOutput("pc_plus4", pc_plus4, rec.pc + 32'd4);
                checkOutput("flush", {31'h0, flush}, {31'h0, rec.flush});
                checkOutput("align_err", {31'h0, align_err}, {31'h0, rec.align});
            end
            if (imem_req === 1'b1 && imem_ready === 1'b1) begin
                if (fetch_q.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL fetch_unexpected: got request pc %h, expected no fetch at %0t",
                             pc, $time);
                end else begin
                    checkOutput("fetch_addr", pc, fetch_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic r_rst, r_stall, r_br, r_jmp, r_ready;
        logic [31:0] r_off, r_base;
        modelReset();
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_off_x4 = 32'h0;
        redir_base_pc = 32'h0; jump = 1'b0; jump_idx = 26'h0; imem_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset, one BOOT cycle, then sequential fetch 0x0..0xC
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h40, 32'h100, 1'b0, 26'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 26'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h40, 32'h100, 1'b0, 26'h0, 1'b1);
        repeat (4) idle(1'b1);

        // Branch to 0xD53C
        branch(32'h100, 32'h0000_D43C, 1'b1);
        repeat (2) idle(1'b1);

        // Negative offset and pc+4 wrap
        branch(32'h8, 32'hFFFF_FFF0, 1'b1);
        idle(1'b1);
        branch(32'h0, 32'hFFFF_FFFC, 1'b1);
        repeat (3) idle(1'b1);

        // Pending redirect resolved by a later acceptance
        branch(32'h1F0, 32'h10, 1'b0);
        repeat (2) idle(1'b0);
        repeat (2) idle(1'b1);

        // Pending redirect lost on reset
        branch(32'h300, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 26'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 26'h0, 1'b1);
        repeat (3) idle(1'b1);

        // Jump beats branch; stall holds pc; misaligned branch target
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h1234, 32'hA000_0100, 1'b1, 26'h40, 1'b1);
        idle(1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 26'h0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0, 32'h102, 1'b0, 26'h0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 26'h0, 1'b1);
        repeat (3) idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            r_rst   = ($urandom_range(0, 79) != 0);
            r_stall = ($urandom_range(0, 4) == 0);
            r_br    = ($urandom_range(0, 6) == 0);
            r_jmp   = ($urandom_range(0, 9) == 0);
            r_ready = ($urandom_range(0, 9) < 7);
            r_off   = $urandom;
            if ($urandom_range(0, 3) != 0) r_off = r_off & 32'hFFFF_FFFC;
            r_base  = $urandom & 32'hFFFF_FFFC;
            applyStimulus(r_rst, r_stall, r_br, r_off, r_base, r_jmp, 26'($urandom), r_ready);
        end

        repeat (3) idle(1'b0);
        @(negedge clk);
        #1;
        checkOutput("fetch_queue_drained", 32'(fetch_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
